mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit of the pipelined RV32I core; consumes the EX/MEM pipeline register outputs.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/mem_stage_lsu.sv | 147 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// access size encodings, FSM state type and default abort limit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int LSU_TIMEOUT = 16;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU (purely combinational).
// Ports: st_size/st_off/st_wdata -> st_data/st_strb/misalign (store side,
//        live request); ld_size/ld_off/ld_uns/prdata -> ld_data (load side,
//        latched request).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic        misalign,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_uns,
    input  logic [31:0] prdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_data  = st_wdata;
        st_strb  = 4'b1111;
        misalign = 1'b0;
        case (st_size)
            SZ_B: begin
                st_data = {4{st_wdata[7:0]}};
                st_strb = 4'b0001 << st_off;
            end
            SZ_H: begin
                st_data  = {2{st_wdata[15:0]}};
                st_strb  = 4'b0011 << st_off;
                misalign = st_off[0];
            end
            default: begin
                // reserved size 2'b11 behaves as a word
                misalign = |st_off;
            end
        endcase
    end

    always_comb begin
        shifted = prdata >> {ld_off, 3'b000};
        ld_data = shifted;
        case (ld_size)
            SZ_B: ld_data = ld_uns ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: ld_data = ld_uns ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns EX/MEM load/store requests into APB
// master transfers, stalls the pipeline meanwhile, returns extended load data.
// Ports: clk, rst (async high); MemWriteM, MemReadM, LoadUnsM, MemStrobeM,
//        ALUResultM, WriteDataM in; StallM, ReadDataM, MisalignM, BusErrM out;
//        APB master: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB out;
//        PRDATA, PREADY, PSLVERR in.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic              LoadUnsM,
    input  logic [1:0]        MemStrobeM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic              StallM,
    output logic [31:0]       ReadDataM,
    output logic              MisalignM,
    output logic              BusErrM,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic [1:0]     size_q;
    logic [1:0]     off_q;
    logic           uns_q;
    logic           err_q;
    logic [31:0]    rdata_q;

    logic           req;
    logic           is_store;
    logic [31:0]    st_data;
    logic [3:0]     st_strb;
    logic           misalign;
    logic [31:0]    ld_data;
    logic [31:0]    addr_al;

    // a request with both bits set is handled as a store
    assign req      = MemWriteM | MemReadM;
    assign is_store = MemWriteM;
    assign addr_al  = {ALUResultM[31:2], 2'b00};
    assign cnt_n    = cnt + 1'b1;

    lsu_lane_align u_align (
        .st_size  (MemStrobeM),
        .st_off   (ALUResultM[1:0]),
        .st_wdata (WriteDataM),
        .st_data  (st_data),
        .st_strb  (st_strb),
        .misalign (misalign),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_uns   (uns_q),
        .prdata   (PRDATA),
        .ld_data  (ld_data)
    );

    // rst gating lets the stall drop in the same cycle reset is raised
    assign StallM = !rst &&
                    ((state == IDLE && req && !misalign) ||
                     state == SETUP || state == ACCESS);
    assign MisalignM = !rst && state == IDLE && req && misalign;
    assign BusErrM   = state == DONE && err_q;
    assign ReadDataM = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= 32'h0;
            PSTRB   <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !misalign) begin
                        state  <= SETUP;
                        PSEL   <= 1'b1;
                        PWRITE <= is_store;
                        PADDR  <= ADDR_W'(addr_al);
                        PWDATA <= st_data;
                        PSTRB  <= is_store ? st_strb : 4'h0;
                        size_q <= MemStrobeM;
                        off_q  <= ALUResultM[1:0];
                        uns_q  <= LoadUnsM;
                        cnt    <= '0;
                        err_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state   <= DONE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        err_q   <= PSLVERR;
                        rdata_q <= (PSLVERR || PWRITE) ? 32'h0 : ld_data;
                    end else if (cnt_n == CW'(TIMEOUT)) begin
                        state   <= DONE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        cnt <= cnt_n;
                    end
                end
                DONE: begin
                    // load data is only presented for the DONE cycle
                    state   <= IDLE;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
// Drives the EX/MEM request and plays a hand-scripted APB slave.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWriteM, MemReadM, LoadUnsM;
    logic [1:0]  MemStrobeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, MisalignM, BusErrM;
    logic [31:0] ReadDataM;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM), .LoadUnsM(LoadUnsM),
        .MemStrobeM(MemStrobeM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .StallM(StallM), .ReadDataM(ReadDataM),
        .MisalignM(MisalignM), .BusErrM(BusErrM),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic w, input logic r, input logic u,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        MemWriteM  = w;
        MemReadM   = r;
        LoadUnsM   = u;
        MemStrobeM = sz;
        ALUResultM = a;
        WriteDataM = wd;
    endtask

    // from SETUP: slave answers at once, leaves bench in the DONE cycle
    task automatic xfer_tail(input logic [31:0] rd, input logic err);
        PRDATA  = rd;
        PSLVERR = err;
        PREADY  = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_req();
        setin(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic pen_ok;
        rst = 1'b1;
        PRDATA = 32'h0;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        setin(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pstrb", PSTRB, 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_stall", StallM, 0);
        tick();
        rst = 1'b0;
        tick();

        // SW 0xDEADBEEF @0x10
        setin(1'b1, 1'b0, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF);
        #1;
        chk("sw_stall_idle", StallM, 1);
        tick();
        chk("sw_psel", PSEL, 1);
        chk("sw_penable_setup", PENABLE, 0);
        chk("sw_paddr", PADDR, 32'h10);
        chk("sw_pwdata", PWDATA, 32'hDEADBEEF);
        chk("sw_pstrb", PSTRB, 4'hF);
        chk("sw_pwrite", PWRITE, 1);
        chk("sw_stall_setup", StallM, 1);
        PREADY = 1'b1;
        tick();
        chk("sw_penable_access", PENABLE, 1);
        chk("sw_stall_access", StallM, 1);
        tick();
        chk("sw_stall_done", StallM, 0);
        chk("sw_buserr", BusErrM, 0);
        chk("sw_psel_done", PSEL, 0);
        release_req();

        // LB @0x13 signed / unsigned
        setin(1'b0, 1'b1, 1'b0, 2'b00, 32'h13, 32'h0);
        tick();
        chk("lb_paddr", PADDR, 32'h10);
        chk("lb_pstrb", PSTRB, 4'h0);
        chk("lb_pwrite", PWRITE, 0);
        xfer_tail(32'h80FF_0000, 1'b0);
        chk("lb_rdata", ReadDataM, 32'hFFFFFF80);
        chk("lb_stall_done", StallM, 0);
        release_req();
        chk("lb_rdata_idle", ReadDataM, 32'h0);
        setin(1'b0, 1'b1, 1'b1, 2'b00, 32'h13, 32'h0);
        tick();
        xfer_tail(32'h80FF_0000, 1'b0);
        chk("lbu_rdata", ReadDataM, 32'h00000080);
        release_req();

        // LH @0x22 signed
        setin(1'b0, 1'b1, 1'b0, 2'b01, 32'h22, 32'h0);
        tick();
        xfer_tail(32'h8765_1234, 1'b0);
        chk("lh_rdata", ReadDataM, 32'hFFFF8765);
        release_req();

        // SH @0x22, SB @0x11
        setin(1'b1, 1'b0, 1'b0, 2'b01, 32'h22, 32'h1234ABCD);
        tick();
        chk("sh_pstrb", PSTRB, 4'b1100);
        chk("sh_pwdata", PWDATA, 32'hABCDABCD);
        chk("sh_paddr", PADDR, 32'h20);
        xfer_tail(32'h0, 1'b0);
        chk("sh_buserr", BusErrM, 0);
        release_req();
        setin(1'b1, 1'b0, 1'b0, 2'b00, 32'h11, 32'h000000A5);
        tick();
        chk("sb_pstrb", PSTRB, 4'b0010);
        chk("sb_pwdata", PWDATA, 32'hA5A5A5A5);
        xfer_tail(32'h0, 1'b0);
        release_req();

        // LH @0x21 misaligned
        setin(1'b0, 1'b1, 1'b0, 2'b01, 32'h21, 32'h0);
        #1;
        chk("mis_pulse", MisalignM, 1);
        chk("mis_stall", StallM, 0);
        chk("mis_rdata", ReadDataM, 0);
        tick();
        chk("mis_psel", PSEL, 0);
        setin(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk("mis_clear", MisalignM, 0);
        tick();
        chk("mis_psel2", PSEL, 0);

        // LW @0x40, PREADY stuck low -> timeout
        setin(1'b0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        PREADY = 1'b0;
        tick();
        chk("to_psel", PSEL, 1);
        n = 0;
        pen_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!StallM) break;
            if (PENABLE !== 1'b1) pen_ok = 1'b0;
            n++;
        end
        chk("to_access_cycles", n, 16);
        chk("to_penable_held", pen_ok, 1);
        chk("to_buserr", BusErrM, 1);
        chk("to_rdata", ReadDataM, 0);
        chk("to_psel_done", PSEL, 0);
        release_req();
        chk("to_buserr_idle", BusErrM, 0);
        chk("to_stall_idle", StallM, 0);

        // LW with PSLVERR
        setin(1'b0, 1'b1, 1'b0, 2'b10, 32'h44, 32'h0);
        tick();
        xfer_tail(32'h12345678, 1'b1);
        chk("err_buserr", BusErrM, 1);
        chk("err_rdata", ReadDataM, 0);
        release_req();

        // back-to-back SW then LW
        setin(1'b1, 1'b0, 1'b0, 2'b10, 32'h50, 32'hCAFEF00D);
        tick();
        chk("b2b_sw_pwdata", PWDATA, 32'hCAFEF00D);
        xfer_tail(32'h0, 1'b0);
        chk("b2b_sw_done", StallM, 0);
        setin(1'b0, 1'b1, 1'b0, 2'b10, 32'h50, 32'h0);
        PREADY = 1'b0;
        tick();
        chk("b2b_lw_stall_idle", StallM, 1);
        chk("b2b_lw_psel_idle", PSEL, 0);
        tick();
        chk("b2b_lw_pwrite", PWRITE, 0);
        chk("b2b_lw_paddr", PADDR, 32'h50);
        xfer_tail(32'hCAFEF00D, 1'b0);
        chk("b2b_lw_rdata", ReadDataM, 32'hCAFEF00D);
        release_req();

        // async reset in ACCESS
        setin(1'b0, 1'b1, 1'b0, 2'b10, 32'h60, 32'h0);
        PREADY = 1'b0;
        tick();
        tick();
        tick();
        chk("ar_penable_pre", PENABLE, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_psel", PSEL, 0);
        chk("ar_penable", PENABLE, 0);
        chk("ar_stall", StallM, 0);
        #2;
        rst = 1'b0;
        setin(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("ar_psel_after", PSEL, 0);
        chk("ar_stall_after", StallM, 0);
        setin(1'b1, 1'b0, 1'b0, 2'b10, 32'h70, 32'h11223344);
        #1;
        chk("ar_new_stall", StallM, 1);
        tick();
        chk("ar_new_psel", PSEL, 1);
        chk("ar_new_penable", PENABLE, 0);
        chk("ar_new_paddr", PADDR, 32'h70);
        xfer_tail(32'h0, 1'b0);
        chk("ar_new_done", StallM, 0);
        release_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
